scarv_cop_aes_lanes: RTL

Parametrised AES coprocessor unit with a configurable number of S-box and MixColumn byte lanes. It trades area against latency. It captures its operands at issue and builds the full 32-bit result in an internal register. It then writes the whole word back once, with a single idone pulse. It sits in the coprocessor execute stage, on the same dispatch and writeback path as the other functional units. It adds operand capture, flush/abort handling and a busy indication.

---
 rtl/scarv_cop_aes_lanes.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/scarv_cop_aes_lanes.sv
// AES S-box / MixColumn coprocessor unit with a configurable number of byte lanes.
// Operands are captured at issue, the result is built over 4/L steps and written back once.
module scarv_cop_aes_lanes #(
    parameter int SBOX_LANES = 1,
    parameter int MIX_LANES  = 1
) (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        aes_ivalid,
    input  logic        aes_flush,
    input  logic [31:0] aes_rs1,
    input  logic [31:0] aes_rs2,
    input  logic [4:0]  id_subclass,
    output logic        aes_busy,
    output logic        aes_idone,
    output logic [3:0]  aes_cpr_rd_ben,
    output logic [31:0] aes_cpr_rd_wdata
);

    // Handshake: aes_ivalid is accepted in IDLE unless aes_flush is high, and must
    // then stay high until the single-cycle aes_idone; dropping it earlier aborts.
    if (!(SBOX_LANES == 1 || SBOX_LANES == 2 || SBOX_LANES == 4)) begin : g_bad_sbox_lanes
        $error("SBOX_LANES must be 1, 2 or 4");
    end
    if (!(MIX_LANES == 1 || MIX_LANES == 2 || MIX_LANES == 4)) begin : g_bad_mix_lanes
        $error("MIX_LANES must be 1, 2 or 4");
    end

    localparam logic [4:0] SCLASS_AESSUB_ENC    = 5'b10000;
    localparam logic [4:0] SCLASS_AESSUB_ENCROT = 5'b10010;
    localparam logic [4:0] SCLASS_AESSUB_DEC    = 5'b10001;
    localparam logic [4:0] SCLASS_AESSUB_DECROT = 5'b10011;
    localparam logic [4:0] SCLASS_AESMIX_ENC    = 5'b11000;
    localparam logic [4:0] SCLASS_AESMIX_DEC    = 5'b11001;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COMPUTE = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    localparam logic [1:0] SUB_LAST = 2'(4 / SBOX_LANES - 1);
    localparam logic [1:0] MIX_LAST = 2'(4 / MIX_LANES - 1);

    // GF(2^8) arithmetic modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 = a^2 * a^4 * ... * a^128; maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox_affine(input logic [7:0] b);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] sbox_inv_affine(input logic [7:0] b);
        return rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ 8'h05;
    endfunction

    function automatic logic [7:0] mix_byte(input logic [7:0] a0, input logic [7:0] a1,
                                            input logic [7:0] a2, input logic [7:0] a3,
                                            input logic dec);
        if (dec)
            return gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
        return xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    endfunction

    logic [1:0]       state_q, state_d;
    logic [1:0]       step_q, step_d;
    logic [3:0][7:0]  col_q, col_d;
    logic [4:0]       sub_q, sub_d;
    logic [31:0]      result_q, result_d;

    logic             issue;
    logic             issue_known;
    logic             is_sub_q;
    logic             is_mix_q;
    logic             dec_q;
    logic             rot_q;
    logic [1:0]       step_last;
    logic             done_vis;
    logic [31:0]      wb_word;

    // Only the column bytes are captured; the other operand bytes never reach the datapath.
    logic unused_rs_bits;
    assign unused_rs_bits = ^{aes_rs1[31:24], aes_rs1[15:8], aes_rs2[23:16], aes_rs2[7:0]};

    assign issue       = (state_q == ST_IDLE) && aes_ivalid && !aes_flush;
    assign issue_known = id_subclass inside {SCLASS_AESSUB_ENC, SCLASS_AESSUB_ENCROT,
                                             SCLASS_AESSUB_DEC, SCLASS_AESSUB_DECROT,
                                             SCLASS_AESMIX_ENC, SCLASS_AESMIX_DEC};

    assign is_sub_q  = sub_q inside {SCLASS_AESSUB_ENC, SCLASS_AESSUB_ENCROT,
                                     SCLASS_AESSUB_DEC, SCLASS_AESSUB_DECROT};
    assign is_mix_q  = sub_q inside {SCLASS_AESMIX_ENC, SCLASS_AESMIX_DEC};
    assign dec_q     = sub_q inside {SCLASS_AESSUB_DEC, SCLASS_AESSUB_DECROT, SCLASS_AESMIX_DEC};
    assign rot_q     = sub_q inside {SCLASS_AESSUB_ENCROT, SCLASS_AESSUB_DECROT};
    assign step_last = is_sub_q ? SUB_LAST : MIX_LAST;

    logic [1:0] sb_idx [SBOX_LANES];
    logic [7:0] sb_out [SBOX_LANES];
    logic [1:0] mx_idx [MIX_LANES];
    logic [7:0] mx_out [MIX_LANES];

    // Forward and inverse S-box share one inverter per lane.
    for (genvar j = 0; j < SBOX_LANES; j++) begin : g_sbox_lane
        logic [7:0] sb_in;
        logic [7:0] inv_in;
        logic [7:0] inv_out;
        assign sb_idx[j] = step_q * 2'(SBOX_LANES) + 2'(j);
        assign sb_in     = col_q[sb_idx[j]];
        assign inv_in    = dec_q ? sbox_inv_affine(sb_in) : sb_in;
        assign inv_out   = gf_inv(inv_in);
        assign sb_out[j] = dec_q ? inv_out : sbox_affine(inv_out);
    end

    for (genvar j = 0; j < MIX_LANES; j++) begin : g_mix_lane
        logic [1:0] i1;
        logic [1:0] i2;
        logic [1:0] i3;
        assign mx_idx[j] = step_q * 2'(MIX_LANES) + 2'(j);
        assign i1        = mx_idx[j] + 2'd1;
        assign i2        = mx_idx[j] + 2'd2;
        assign i3        = mx_idx[j] + 2'd3;
        assign mx_out[j] = mix_byte(col_q[mx_idx[j]], col_q[i1], col_q[i2], col_q[i3], dec_q);
    end

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        col_d    = col_q;
        sub_d    = sub_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (issue) begin
                    col_d    = {aes_rs2[31:24], aes_rs1[23:16], aes_rs2[15:8], aes_rs1[7:0]};
                    sub_d    = id_subclass;
                    step_d   = 2'd0;
                    result_d = 32'h0;
                    state_d  = issue_known ? ST_COMPUTE : ST_DONE;
                end
            end
            ST_COMPUTE: begin
                if (is_sub_q) begin
                    for (int j = 0; j < SBOX_LANES; j++)
                        result_d[{sb_idx[j], 3'b000} +: 8] = sb_out[j];
                end else begin
                    for (int j = 0; j < MIX_LANES; j++)
                        result_d[{mx_idx[j], 3'b000} +: 8] = mx_out[j];
                end
                step_d = step_q + 2'd1;
                if (aes_flush || !aes_ivalid)
                    state_d = ST_IDLE;
                else if (step_q == step_last)
                    state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state_q  <= ST_IDLE;
            step_q   <= 2'd0;
            col_q    <= '0;
            sub_q    <= 5'd0;
            result_q <= 32'h0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            col_q    <= col_d;
            sub_q    <= sub_d;
            result_q <= result_d;
        end
    end

    // A flush in the DONE cycle suppresses the writeback in that same cycle.
    assign done_vis = (state_q == ST_DONE) && !aes_flush;
    assign wb_word  = rot_q ? {result_q[23:0], result_q[31:24]} : result_q;

    assign aes_busy         = (state_q != ST_IDLE);
    assign aes_idone        = done_vis;
    assign aes_cpr_rd_ben   = (done_vis && (is_sub_q || is_mix_q)) ? 4'hF : 4'h0;
    assign aes_cpr_rd_wdata = (done_vis && (is_sub_q || is_mix_q)) ? wb_word : 32'h0;

endmodule
